// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the bit-serial add/subtract slice. It holds the
// controller state encoding and the mode values that drive addsub_halffull.
// -----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD  = 1'b0;
    localparam logic MODE_SUB  = 1'b1;
    localparam logic MODE_HALF = 1'b0;
    localparam logic MODE_FULL = 1'b1;

endpackage

// File: rtl/addsub_halffull.sv
// -----------------------------------------------------------------------------
// addsub_halffull
// Combinational 1-bit adder/subtractor cell. It runs in half or full mode.
//   signal_a, signal_b : operand bits
//   carryborrow_in     : incoming carry (add) or borrow (sub); ignored in half mode
//   mode_addsub        : MODE_ADD / MODE_SUB
//   mode_halffull      : MODE_HALF / MODE_FULL
//   sumdiff            : sum or difference bit
//   carryborrow_out    : outgoing carry (add) or borrow (sub)
// -----------------------------------------------------------------------------
module addsub_halffull
    import addsub_pkg::*;
(
    input  logic signal_a,
    input  logic signal_b,
    input  logic carryborrow_in,
    input  logic mode_addsub,
    input  logic mode_halffull,
    output logic sumdiff,
    output logic carryborrow_out
);

    logic cin_eff;
    logic axb;

    always_comb begin
        cin_eff = (mode_halffull == MODE_HALF) ? 1'b0 : carryborrow_in;
        axb     = signal_a ^ signal_b;
        sumdiff = axb ^ cin_eff;
        if (mode_addsub == MODE_SUB) begin
            // Borrow when b exceeds a, or when they are equal and a borrow is pending.
            carryborrow_out = (~signal_a & signal_b) | (~axb & cin_eff);
        end else begin
            carryborrow_out = (signal_a & signal_b) | (axb & cin_eff);
        end
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl
// Bit-serial WIDTH-bit add/subtract sequencer built around addsub_halffull.
// It latches the operands on start, then processes one bit per clock, LSB
// first. It reports a held result and flags, with a one-cycle done pulse.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : request, sampled in IDLE or DONE only
//   op_sub          : 0 = a + b, 1 = a - b (latched with start)
//   a, b            : WIDTH-bit operands (latched with start)
//   busy            : high while bits are being processed
//   done            : one-cycle pulse when result/flags update
//   result          : last completed sum/difference (held)
//   carryborrow_out : final carry/borrow (held)
//   overflow        : signed two's-complement overflow (held)
// -----------------------------------------------------------------------------
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryborrow_out,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, res_sr_d;
    logic             op_q, cb_q;
    logic [WIDTH-1:0] result_q;
    logic             cbo_q, ovf_q;

    logic load, step, finish;
    logic cell_sd, cell_cbo;
    logic ovf_d;

    addsub_halffull u_cell (
        .signal_a        (a_sr_q[0]),
        .signal_b        (b_sr_q[0]),
        .carryborrow_in  (cb_q),
        .mode_addsub     (op_q),
        .mode_halffull   (MODE_FULL),
        .sumdiff         (cell_sd),
        .carryborrow_out (cell_cbo)
    );

    // The new bit enters at the MSB; after WIDTH shifts the LSB is bit 0.
    assign res_sr_d = WIDTH'({cell_sd, res_sr_q} >> 1);

    // On the last bit the operand registers have shifted WIDTH-1 times, so
    // their LSBs are the original operand MSBs. The cell output is the result MSB.
    assign ovf_d = ((a_sr_q[0] ^ b_sr_q[0]) == op_q) && (cell_sd != a_sr_q[0]);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            op_q     <= 1'b0;
            cb_q     <= 1'b0;
            cnt_q    <= '0;
        end else if (load) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            res_sr_q <= '0;
            op_q     <= op_sub;
            cb_q     <= 1'b0;
            cnt_q    <= '0;
        end else if (step) begin
            a_sr_q   <= a_sr_q >> 1;
            b_sr_q   <= b_sr_q >> 1;
            res_sr_q <= res_sr_d;
            cb_q     <= cell_cbo;
            // Hold at the last bit index instead of wrapping.
            if (!finish) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            cbo_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (finish) begin
            result_q <= res_sr_d;
            cbo_q    <= cell_cbo;
            ovf_q    <= ovf_d;
        end
    end

    assign busy            = (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign result          = result_q;
    assign carryborrow_out = cbo_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
module tb_serial_addsub_ctrl;
    import addsub_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result;
    logic         carryborrow_out, overflow;

    int tests = 0;
    int fails = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .op_sub          (op_sub),
        .a               (a),
        .b               (b),
        .busy            (busy),
        .done            (done),
        .result          (result),
        .carryborrow_out (carryborrow_out),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] ta;
        logic [7:0] tb;
        logic       ts;
        logic [7:0] er;
        logic       ec;
        logic       ev;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Arithmetic reference: unsigned/signed integer math, not bit-level.
    task automatic model(input logic [7:0] x, input logic [7:0] y, input logic s,
                         output logic [7:0] r, output logic c, output logic v);
        int ux, uy, sx, sy, full, sres;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            full = ux + uy;
            c    = (full > 255);
            sres = sx + sy;
        end else begin
            full = ux - uy;
            c    = (ux < uy);
            sres = sx - sy;
        end
        r = full[7:0];
        v = (sres > 127) || (sres < -128);
    endtask

    // Called #1 after a clock edge; returns #1 after the sampling edge E0.
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
        start  = 1'b1;
        a      = ta;
        b      = tb;
        op_sub = ts;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit junk, output int edges, output int bcnt, output bit held);
        logic [7:0] prev;
        prev  = result;
        held  = 1'b1;
        edges = 1;
        bcnt  = busy ? 1 : 0;
        while (!done && edges < 20) begin
            if (junk) begin
                if (edges >= 2 && edges <= 5) begin
                    start  = 1'b1;
                    a      = 8'($urandom);
                    b      = 8'($urandom);
                    op_sub = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            edges++;
            if (busy) bcnt++;
            if (!done && result !== prev) held = 1'b0;
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                          input logic [7:0] er, input logic ec, input logic ev,
                          input bit junk, input string nm);
        int e, bc;
        bit h;
        issue(ta, tb, ts);
        chk({nm, " busy@E0"}, 32'(busy), 32'd1);
        chk({nm, " done@E0"}, 32'(done), 32'd0);
        wait_done(junk, e, bc, h);
        chk({nm, " edges_to_done"}, 32'(e), 32'd9);
        chk({nm, " busy_cycles"}, 32'(bc), 32'd8);
        chk({nm, " prev_result_held"}, 32'(h), 32'd1);
        chk({nm, " result"}, 32'(result), 32'(er));
        chk({nm, " cbo"}, 32'(carryborrow_out), 32'(ec));
        chk({nm, " ovf"}, 32'(overflow), 32'(ev));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " done"}, 32'(done), 32'd0);
        chk({nm, " result"}, 32'(result), 32'd0);
        chk({nm, " cbo"}, 32'(carryborrow_out), 32'd0);
        chk({nm, " ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        vec_t vecs[7];
        logic [7:0] rr;
        logic cc, vv;
        bit done_seen;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[6] = '{8'h0F, 8'h0E, 1'b1, 8'h01, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table of directed vectors, each followed by the done-pulse fall.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].ta, vecs[i].tb, vecs[i].ts, vecs[i].er, vecs[i].ec, vecs[i].ev,
                   1'b0, $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d done_pulse_end", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d idle_busy", i), 32'(busy), 32'd0);
        end

        // Start toggled during RUN with other operands is ignored.
        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, "start_in_run");
        // Back-to-back: start issued in the DONE cycle; 0x7F must hold meanwhile.
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "back_to_back");
        @(posedge clk);
        #1;
        chk("b2b done_pulse_end", 32'(done), 32'd0);

        // Asynchronous reset in the middle of a run.
        run_op(8'hFF, 8'h80, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, "pre_reset");
        @(posedge clk);
        #1;
        issue(8'h35, 8'h4A, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen = 1'b1;
        end
        chk("after_reset no_done_or_busy", 32'(done_seen), 32'd0);
        chk("after_reset result", 32'(result), 32'd0);
        run_op(8'h0F, 8'h0E, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, "post_reset");

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ra, rb;
            logic rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            if (n == 0) begin ra = 8'h80; rb = 8'h80; rs = 1'b0; end
            if (n == 1) begin ra = 8'h00; rb = 8'hFF; rs = 1'b1; end
            model(ra, rb, rs, rr, cc, vv);
            run_op(ra, rb, rs, rr, cc, vv, 1'b0, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
                chk($sformatf("rnd%0d done_pulse_end", n), 32'(done), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
